cacheline_mem_adapter: RTL

//  Initiator side of the banked burst-memory interface. Converts one 256-bit cacheline

---
 rtl/mem_adapter_pkg.sv | 39 +++
 rtl/cacheline_mem_adapter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_adapter_pkg.sv
// Shared types and constants for the cacheline <-> burst-memory adapter.
//  - adapter_state_t : FSM state encoding
//  - BEAT_W / BEATS  : burst beat width and beats per line; LINE_W is their product
//  - OFFSET_W        : byte-offset bits dropped when aligning a line address
//  - get_beat / merge_beat : slice and insert one beat in a line
package mem_adapter_pkg;

  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int LINE_W   = BEAT_W * BEATS;
  localparam int OFFSET_W = 5;
  localparam int BEAT_IW  = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BURST = 3'd1,
    ST_RD_REQ   = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_BURST = 3'd4,
    ST_RESP     = 3'd5
  } adapter_state_t;

  // Beat idx of a line; beat 0 occupies the least significant bits.
  function automatic logic [BEAT_W-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_IW-1:0] idx);
    return line[idx*BEAT_W +: BEAT_W];
  endfunction

  // Copy of line with beat idx replaced by data.
  function automatic logic [LINE_W-1:0] merge_beat(input logic [LINE_W-1:0] line,
                                                    input logic [BEAT_IW-1:0] idx,
                                                    input logic [BEAT_W-1:0] data);
    logic [LINE_W-1:0] res;
    res = line;
    res[idx*BEAT_W +: BEAT_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/cacheline_mem_adapter.sv
// Initiator side of the banked burst-memory interface. One 256-bit line request
// from the cache side (dfp_*) becomes a 4-beat burst on bmem_*; returning read
// beats tagged with the request address are reassembled into a line.
// Ports:
//  clk, rst_n          clock, synchronous active-low reset
//  dfp_addr/read/write/wdata  line request (held until dfp_resp)
//  dfp_rdata, dfp_resp read line and one-cycle completion pulse
//  bmem_addr/read/write/wdata command and write-beat outputs
//  bmem_ready          memory accepts command/beat at this posedge
//  bmem_raddr/rdata/rvalid    returning read beats
//  error               sticky protocol/timeout flag, cleared only by reset
// All outputs are registered. Beat width and beat count come from mem_adapter_pkg.
module cacheline_mem_adapter
  import mem_adapter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              error
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

  adapter_state_t     state_q;
  logic [BEAT_IW-1:0] beat_q;
  logic [TIMER_W-1:0] timer_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  line_q;       // write line, or read line under assembly
  logic [LINE_W-1:0]  dfp_rdata_q;  // last completed read line
  logic               dfp_resp_q;
  logic               bmem_read_q;
  logic               bmem_write_q;
  logic [BEAT_W-1:0]  bmem_wdata_q;
  logic               error_q;

  logic [ADDR_W-1:0]  line_addr_s;
  logic [BEAT_IW-1:0] beat_nxt_s;
  logic               last_beat_s;
  logic               raddr_hit_s;
  logic               timeout_s;
  logic               addr_offset_unused_s;

  assign line_addr_s          = {dfp_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign addr_offset_unused_s = ^dfp_addr[OFFSET_W-1:0];
  assign beat_nxt_s           = beat_q + 1'b1;
  assign last_beat_s          = (beat_q == BEAT_IW'(BEATS - 1));
  assign raddr_hit_s          = (bmem_raddr == addr_q);
  assign timeout_s            = (timer_q == TIMER_W'(TIMEOUT_CYC));

  // Transaction FSM with beat counter, timeout counter and line assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      timer_q      <= '0;
      addr_q       <= '0;
      line_q       <= '0;
      dfp_rdata_q  <= '0;
      dfp_resp_q   <= 1'b0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
      error_q      <= 1'b0;
    end else begin
      // A read beat is only expected while waiting for or receiving a burst.
      if (bmem_rvalid && (state_q != ST_RD_WAIT) && (state_q != ST_RD_BURST)) begin
        error_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          beat_q  <= '0;
          timer_q <= '0;
          if (dfp_read) begin
            // Read wins a simultaneous read/write; the conflict is flagged.
            if (dfp_write) begin
              error_q <= 1'b1;
            end
            addr_q      <= line_addr_s;
            bmem_read_q <= 1'b1;
            state_q     <= ST_RD_REQ;
          end else if (dfp_write) begin
            addr_q       <= line_addr_s;
            line_q       <= dfp_wdata;
            bmem_write_q <= 1'b1;
            bmem_wdata_q <= get_beat(dfp_wdata, '0);
            state_q      <= ST_WR_BURST;
          end
        end

        ST_WR_BURST: begin
          if (bmem_ready) begin
            if (last_beat_s) begin
              bmem_write_q <= 1'b0;
              dfp_resp_q   <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              beat_q       <= beat_nxt_s;
              bmem_wdata_q <= get_beat(line_q, beat_nxt_s);
            end
          end
        end

        ST_RD_REQ: begin
          if (bmem_ready) begin
            bmem_read_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          // Timer saturates; the error stays raised while still waiting.
          if (timeout_s) begin
            error_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
          if (bmem_rvalid) begin
            if (raddr_hit_s) begin
              line_q  <= merge_beat(line_q, '0, bmem_rdata);
              beat_q  <= BEAT_IW'(1);
              state_q <= ST_RD_BURST;
            end else begin
              error_q <= 1'b1;  // stray burst, beat dropped
            end
          end
        end

        ST_RD_BURST: begin
          if (bmem_rvalid) begin
            line_q <= merge_beat(line_q, beat_q, bmem_rdata);
            if (last_beat_s) begin
              // Publish the whole line only once it is complete.
              dfp_rdata_q <= merge_beat(line_q, beat_q, bmem_rdata);
              dfp_resp_q  <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              beat_q <= beat_nxt_s;
            end
          end else begin
            error_q <= 1'b1;  // gap inside a burst; beat position kept
          end
        end

        ST_RESP: begin
          dfp_resp_q <= 1'b0;
          beat_q     <= '0;
          state_q    <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dfp_rdata  = dfp_rdata_q;
  assign dfp_resp   = dfp_resp_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;
  assign error      = error_q;

endmodule
